sa_matmul_pcpi: RTL and testbench
=================================

Name: sa_matmul_pcpi

Overview:
- Parametrised successor to the fixed 3x3 fused matrix-multiply PCPI coprocessor.
- Holds NxN signed operand matrices A and B, a bias matrix and a threshold; computes C = A*B + bias on an NxN output-stationary systolic array.
- Returns either a packed threshold bitmap or individual accumulators over the PicoRV32 PCPI handshake.
- Sits beside the core on the PCPI bus, custom-0 opcode space.

Parameters:
- N, 3, matrix dimension; legal range 2..5, since N*N must be at most 32. Elaboration error outside that range.
- DATA_W, 16, signed operand, bias and threshold width.
- ACC_W, 32, signed accumulator width; must be at least 2*DATA_W.
- THRESH_RST, -70, threshold value after reset.
- OPCODE, 7'b0001011, claimed major opcode.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcpi_valid  in  1  CPU offers pcpi_insn.
- pcpi_insn  in  32  instruction; [6:0] opcode, [14:12] funct3.
- pcpi_rs1  in  32  index: [9:8] sel (0=A, 1=B, 2=bias, 3=threshold), [7:4] row, [3:0] col.
- pcpi_rs2  in  32  write data; [DATA_W-1:0] used.
- pcpi_wr  out  1  rd writeback enable; meaningful only while pcpi_ready is high.
- pcpi_rd  out  32  result.
- pcpi_wait  out  1  instruction claimed, still busy.
- pcpi_ready  out  1  single-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state including mid-run):
  - All outputs go to 0.
  - A, B, bias and all accumulators clear to 0; threshold loads THRESH_RST.
  - Mask register clears to 0; FSM goes to IDLE.
- Claim rule: the block claims an instruction only when pcpi_valid is high, opcode equals OPCODE, funct3 is in {000, 001, 010, 011, 111}, and the FSM is in IDLE. Any other instruction gets no response, so the CPU traps.
- FSM states: IDLE, RESP, RUN, LATCH.
  - IDLE: on WRITE, CLEAR, RD_ACC or RD_MASK, perform the action at the accepting edge and go to RESP. On RUN, go to RUN.
  - RESP: pcpi_ready=1 for exactly one cycle, pcpi_wait=0, then go to IDLE.
  - RUN: pcpi_wait=1 for 3N-2 cycles, driven by a feed counter k = 0..3N-3, then go to LATCH.
  - LATCH: pcpi_wait=1; capture mask bit i*N+j = (C[i][j] >= sign-extended threshold), signed compare; then go to RESP.
  - RUN latency: pcpi_ready is high exactly 3N cycles after the accepting edge, i.e. 9 cycles for N=3.
- Commands:
  - funct3=000 WRITE: store rs2[DATA_W-1:0] at (sel, row, col). If row or col is N or greater (sel<3), the write is dropped but still acknowledged. pcpi_wr=0.
  - funct3=001 CLEAR: zero the mask register and accumulators; A, B, bias and threshold are kept. pcpi_wr=0.
  - funct3=010 RD_ACC: pcpi_rd = C[row][col] truncated or sign-extended to 32 bits; 0 if out of range. pcpi_wr=1.
  - funct3=011 RD_MASK: pcpi_rd = zero-extended mask. pcpi_wr=1.
  - funct3=111 RUN: on acceptance, load accumulators with their bias values. pcpi_rd = new mask, pcpi_wr=1.
- Systolic feed during cycle k:
  - Row input r receives A[r][k-r] when 0 <= k-r < N, else 0.
  - Column input c receives B[k-c][c] when 0 <= k-c < N, else 0.
  - Operands shift one PE right/down per cycle. Each PE does acc += a*b, with the full 2*DATA_W signed product sign-extended.
- Arithmetic: accumulators wrap modulo 2^ACC_W; there is no saturation.
- pcpi_valid dropping mid-run (illegal for the core): the run still completes, the mask is latched, and the ready pulse is still issued.
- Ordering: RUN always uses operand values as of its accepting edge, because no write can be accepted while the FSM is busy.
- pcpi_rd holds its value until the next response.

Decomposition:
- Package sa_matmul_pkg holds:
  - funct3 constants F_WRITE, F_CLEAR, F_RDACC, F_RDMASK, F_RUN;
  - sel constants SEL_A, SEL_B, SEL_BIAS, SEL_THR;
  - state enum.
- One sub-module, sa_mac_pe: registered a/b pass-through, accumulator with load-bias input and enable. Instantiated NxN by generate.

Test Plan (N=3, DATA_W=16, ACC_W=32):
- A=identity, B=row-major 1..9, bias=0, threshold=5; RUN -> pcpi_ready exactly 9 cycles after accept, pcpi_wr=1, pcpi_rd=0x000001F0.
- Same setup, then RD_ACC (2,1) -> pcpi_rd=0x00000008, ready 1 cycle after accept, pcpi_wait never high.
- A=B=identity, bias all -10, threshold left at reset (-70); RUN -> 0x000001FF. Then WRITE threshold=-9 and RUN -> 0x00000111; RD_ACC (1,1) -> 0xFFFFFFF7.
- A[0][0]=B[0][0]=-32768, all other entries 0; RUN then RD_ACC (0,0) -> 0x40000000.
- Opcode 0110011, or funct3=100 with OPCODE, held valid for 20 cycles -> pcpi_ready, pcpi_wait and pcpi_wr stay 0.
- resetn low at cycle 4 of a RUN -> outputs 0 immediately. After release, RD_MASK -> 0 and RD_ACC (0,0) -> 0.

Source files
------------

// File: rtl/sa_matmul_pkg.sv
// Shared command encodings, operand selectors and FSM state type for the
// systolic matrix-multiply PCPI coprocessor.
package sa_matmul_pkg;

   localparam logic [2:0] F_WRITE  = 3'b000;
   localparam logic [2:0] F_CLEAR  = 3'b001;
   localparam logic [2:0] F_RDACC  = 3'b010;
   localparam logic [2:0] F_RDMASK = 3'b011;
   localparam logic [2:0] F_RUN    = 3'b111;

   localparam logic [1:0] SEL_A    = 2'd0;
   localparam logic [1:0] SEL_B    = 2'd1;
   localparam logic [1:0] SEL_BIAS = 2'd2;
   localparam logic [1:0] SEL_THR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESP,
      ST_RUN,
      ST_LATCH
   } state_t;

endpackage

// File: rtl/sa_matmul_pcpi_pe.sv
// One processing element of the output-stationary array: forwards its a/b
// operands to the right/lower neighbour and accumulates their product.
module sa_mac_pe #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   input  logic                     i_en,
   input  logic                     i_load,
   input  logic signed [DATA_W-1:0] i_bias,
   output logic signed [DATA_W-1:0] o_a,
   output logic signed [DATA_W-1:0] o_b,
   output logic signed [ACC_W-1:0]  o_acc
);

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prodExt;
   logic signed [ACC_W-1:0]    w_biasExt;
   logic signed [DATA_W-1:0]   r_a;
   logic signed [DATA_W-1:0]   r_b;
   logic signed [ACC_W-1:0]    r_acc;

   assign w_prod    = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
   assign w_prodExt = ACC_W'(w_prod);
   assign w_biasExt = ACC_W'(i_bias);

   // Operand pipeline registers; they run every cycle so zeros flush them between runs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= i_a;
         r_b <= i_b;
      end
   end

   // Accumulator: a load (bias or zero) wins over accumulation, which wraps silently
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc <= '0;
      end else if (i_load) begin
         r_acc <= w_biasExt;
      end else if (i_en) begin
         r_acc <= r_acc + w_prodExt;
      end
   end

   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_acc = r_acc;

endmodule

// File: rtl/sa_matmul_pcpi.sv
// PCPI coprocessor computing C = A*B + bias on an NxN systolic array and
// returning a threshold bitmap or single accumulators to the core.
module sa_matmul_pcpi
   import sa_matmul_pkg::*;
#(
   parameter int         N          = 3,
   parameter int         DATA_W     = 16,
   parameter int         ACC_W      = 32,
   parameter int         THRESH_RST = -70,
   parameter logic [6:0] OPCODE     = 7'b0001011
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);

   localparam int            K_W    = 4;
   localparam logic [K_W-1:0] K_LAST = K_W'(3*N-3);

   if (N < 2 || N > 5) begin : g_badN
      $error("sa_matmul_pcpi: N must lie in 2..5");
   end
   if (ACC_W < 2*DATA_W) begin : g_badAcc
      $error("sa_matmul_pcpi: ACC_W must be at least 2*DATA_W");
   end

   state_t                   r_state;
   state_t                   w_nextState;
   logic [K_W-1:0]           r_k;
   logic signed [DATA_W-1:0] r_matA [N][N];
   logic signed [DATA_W-1:0] r_matB [N][N];
   logic signed [DATA_W-1:0] r_bias [N][N];
   logic signed [DATA_W-1:0] r_thr;
   logic [31:0]              r_mask;
   logic [31:0]              r_rd;
   logic                     r_wr;

   logic [2:0]               w_funct3;
   logic [1:0]               w_sel;
   logic [3:0]               w_row;
   logic [3:0]               w_col;
   logic signed [DATA_W-1:0] w_wdata;
   logic                     w_legalF;
   logic                     w_claim;
   logic                     w_ready;
   logic                     w_wait;
   logic                     w_peLoad;
   logic                     w_peClear;
   logic                     w_peEn;
   logic [31:0]              w_accSel;
   logic [31:0]              w_newMask;
   logic signed [DATA_W-1:0] w_rowIn [N];
   logic signed [DATA_W-1:0] w_colIn [N];
   logic signed [DATA_W-1:0] w_aOut  [N][N];
   logic signed [DATA_W-1:0] w_bOut  [N][N];
   logic signed [ACC_W-1:0]  w_acc   [N][N];
   logic                     w_unused;
   logic                     w_unusedEdge;

   assign w_funct3 = pcpi_insn[14:12];
   assign w_sel    = pcpi_rs1[9:8];
   assign w_row    = pcpi_rs1[7:4];
   assign w_col    = pcpi_rs1[3:0];
   assign w_wdata  = pcpi_rs2[DATA_W-1:0];
   assign w_legalF = (w_funct3 == F_WRITE) || (w_funct3 == F_CLEAR) ||
                     (w_funct3 == F_RDACC) || (w_funct3 == F_RDMASK) ||
                     (w_funct3 == F_RUN);
   assign w_claim  = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && w_legalF &&
                     (r_state == ST_IDLE);

   assign w_peLoad  = w_claim && ((w_funct3 == F_RUN) || (w_funct3 == F_CLEAR));
   assign w_peClear = (w_funct3 == F_CLEAR);
   assign w_peEn    = (r_state == ST_RUN);

   assign w_unused = ^{pcpi_insn[31:15], pcpi_insn[11:7], pcpi_rs1[31:10], pcpi_rs2};

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus handshake outputs; a run holds wait through feed and latch cycles
   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_wait      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_claim) begin
               w_nextState = (w_funct3 == F_RUN) ? ST_RUN : ST_RESP;
            end
         end
         ST_RESP: begin
            w_ready     = 1'b1;
            w_nextState = ST_IDLE;
         end
         ST_RUN: begin
            w_wait = 1'b1;
            if (r_k == K_LAST) begin
               w_nextState = ST_LATCH;
            end
         end
         ST_LATCH: begin
            w_wait      = 1'b1;
            w_nextState = ST_RESP;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Feed counter k counts the skewed diagonals while the array is running
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_k <= '0;
      end else if (r_state == ST_RUN) begin
         r_k <= r_k + 1'b1;
      end else begin
         r_k <= '0;
      end
   end

   // Operand storage; out-of-range matrix writes are silently dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_matA[i][j] <= '0;
               r_matB[i][j] <= '0;
               r_bias[i][j] <= '0;
            end
         end
         r_thr <= DATA_W'(THRESH_RST);
      end else if (w_claim && (w_funct3 == F_WRITE)) begin
         if (w_sel == SEL_THR) begin
            r_thr <= w_wdata;
         end else begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  if ((w_row == 4'(i)) && (w_col == 4'(j))) begin
                     case (w_sel)
                        SEL_A:    r_matA[i][j] <= w_wdata;
                        SEL_B:    r_matB[i][j] <= w_wdata;
                        SEL_BIAS: r_bias[i][j] <= w_wdata;
                        default:  ;
                     endcase
                  end
               end
            end
         end
      end
   end

   // Skewed edge feed: row r sees A[r][k-r], column c sees B[k-c][c], zero otherwise
   always_comb begin
      for (int r = 0; r < N; r++) begin
         w_rowIn[r] = '0;
         w_colIn[r] = '0;
      end
      if (r_state == ST_RUN) begin
         for (int r = 0; r < N; r++) begin
            for (int m = 0; m < N; m++) begin
               if (r_k == K_W'(r + m)) begin
                  w_rowIn[r] = r_matA[r][m];
                  w_colIn[r] = r_matB[m][r];
               end
            end
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic signed [DATA_W-1:0] w_aIn;
         logic signed [DATA_W-1:0] w_bIn;
         logic signed [DATA_W-1:0] w_loadVal;

         if (gj == 0) begin : g_aEdge
            assign w_aIn = w_rowIn[gi];
         end else begin : g_aInner
            assign w_aIn = w_aOut[gi][gj-1];
         end
         if (gi == 0) begin : g_bEdge
            assign w_bIn = w_colIn[gj];
         end else begin : g_bInner
            assign w_bIn = w_bOut[gi-1][gj];
         end
         assign w_loadVal = w_peClear ? '0 : r_bias[gi][gj];

         sa_mac_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk    (clk),
            .resetn (resetn),
            .i_a    (w_aIn),
            .i_b    (w_bIn),
            .i_en   (w_peEn),
            .i_load (w_peLoad),
            .i_bias (w_loadVal),
            .o_a    (w_aOut[gi][gj]),
            .o_b    (w_bOut[gi][gj]),
            .o_acc  (w_acc[gi][gj])
         );
      end
   end

   // Operands leaving the far edges of the array go nowhere
   always_comb begin
      w_unusedEdge = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_unusedEdge = w_unusedEdge ^ (^w_aOut[i][N-1]) ^ (^w_bOut[N-1][i]);
      end
   end

   // Accumulator read mux and signed threshold comparison for the bitmap
   always_comb begin
      w_accSel  = '0;
      w_newMask = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if ((w_row == 4'(i)) && (w_col == 4'(j))) begin
               w_accSel = 32'(w_acc[i][j]);
            end
            w_newMask[i*N+j] = (w_acc[i][j] >= ACC_W'(r_thr));
         end
      end
   end

   // Response data, writeback flag and mask; pcpi_rd holds until replaced
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd   <= '0;
         r_wr   <= 1'b0;
         r_mask <= '0;
      end else if (w_claim) begin
         case (w_funct3)
            F_CLEAR: begin
               r_wr   <= 1'b0;
               r_mask <= '0;
            end
            F_RDACC: begin
               r_wr <= 1'b1;
               r_rd <= w_accSel;
            end
            F_RDMASK: begin
               r_wr <= 1'b1;
               r_rd <= r_mask;
            end
            F_RUN:   r_wr <= 1'b1;
            default: r_wr <= 1'b0;
         endcase
      end else if (r_state == ST_LATCH) begin
         r_mask <= w_newMask;
         r_rd   <= w_newMask;
      end
   end

   assign pcpi_ready = w_ready;
   assign pcpi_wait  = w_wait;
   assign pcpi_wr    = w_ready & r_wr;
   assign pcpi_rd    = r_rd;

endmodule

// File: tb/tb_sa_matmul_pcpi.sv
// Self-checking bench for sa_matmul_pcpi (N=3): directed scenarios plus
// randomized operand traffic compared against a plain matrix-arithmetic model.
module tb_sa_matmul_pcpi;
   import sa_matmul_pkg::*;

   localparam int         N   = 3;
   localparam logic [6:0] OPC = 7'b0001011;

   logic        clk = 1'b0;
   logic        resetn;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   int numChecks = 0;
   int numErrors = 0;

   int          mA    [N][N];
   int          mB    [N][N];
   int          mBias [N][N];
   int          mC    [N][N];
   int          mThr;
   logic [31:0] mMask;

   sa_matmul_pcpi #(
      .N          (N),
      .DATA_W     (16),
      .ACC_W      (32),
      .THRESH_RST (-70),
      .OPCODE     (OPC)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_rs1   (pcpi_rs1),
      .pcpi_rs2   (pcpi_rs2),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (pcpi_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Safety net in case the design never answers at all
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic modelReset();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mA[i][j] = 0; mB[i][j] = 0; mBias[i][j] = 0; mC[i][j] = 0;
         end
      mThr  = -70;
      mMask = '0;
   endtask

   task automatic modelWrite(input logic [31:0] rs1, input logic [31:0] rs2);
      int row  = int'(rs1[7:4]);
      int col  = int'(rs1[3:0]);
      int data = int'($signed(rs2[15:0]));
      if (rs1[9:8] == 2'd3) mThr = data;
      else if (row < N && col < N) begin
         if (rs1[9:8] == 2'd0) mA[row][col] = data;
         else if (rs1[9:8] == 2'd1) mB[row][col] = data;
         else mBias[row][col] = data;
      end
   endtask

   task automatic modelRun();
      mMask = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int s = mBias[i][j];
            for (int k = 0; k < N; k++) s = s + mA[i][k] * mB[k][j];
            mC[i][j] = s;
            if (s >= mThr) mMask[i*N+j] = 1'b1;
         end
   endtask

   task automatic modelClear();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) mC[i][j] = 0;
      mMask = '0;
   endtask

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                                input logic [31:0] rs2, output logic [31:0] rd, output logic wr,
                                output int lat, output logic sawWait);
      logic done = 1'b0;
      @(negedge clk);
      pcpi_insn  = {17'h0, f3, 5'd1, OPC};
      pcpi_rs1   = rs1;
      pcpi_rs2   = rs2;
      pcpi_valid = 1'b1;
      @(posedge clk);
      lat = 0; sawWait = 1'b0; rd = '0; wr = 1'b0;
      while (!done && lat < 50) begin
         @(negedge clk);
         lat++;
         if (pcpi_wait) sawWait = 1'b1;
         if (pcpi_ready) begin
            done = 1'b1;
            rd   = pcpi_rd;
            wr   = pcpi_wr;
         end
      end
      pcpi_valid = 1'b0;
      checkOutput({tag, "_ready_seen"}, {31'b0, done}, 32'd1);
   endtask

   task automatic doWrite(input logic [1:0] sel, input logic [3:0] row, input logic [3:0] col,
                          input logic [31:0] data);
      logic [31:0] rd; logic wr; int lat; logic sw;
      logic [31:0] rs1 = {22'($urandom), sel, row, col};
      applyStimulus("write", F_WRITE, rs1, data, rd, wr, lat, sw);
      modelWrite(rs1, data);
      checkOutput("write_lat", 32'(lat), 32'd1);
      checkOutput("write_wr", {31'b0, wr}, 32'd0);
   endtask

   task automatic doRun(input string tag, output logic [31:0] rd);
      logic wr; int lat; logic sw;
      applyStimulus(tag, F_RUN, 32'h0, 32'h0, rd, wr, lat, sw);
      modelRun();
      checkOutput({tag, "_mask"}, rd, mMask);
      checkOutput({tag, "_lat"}, 32'(lat), 32'(3*N));
      checkOutput({tag, "_wr"}, {31'b0, wr}, 32'd1);
      checkOutput({tag, "_wait"}, {31'b0, sw}, 32'd1);
   endtask

   task automatic doRdAcc(input string tag, input logic [3:0] row, input logic [3:0] col,
                          output logic [31:0] rd);
      logic wr; int lat; logic sw;
      logic [31:0] exp = '0;
      applyStimulus(tag, F_RDACC, {22'($urandom), 2'($urandom), row, col}, $urandom, rd, wr, lat, sw);
      if (int'(row) < N && int'(col) < N) exp = 32'(mC[row][col]);
      checkOutput({tag, "_rd"}, rd, exp);
      checkOutput({tag, "_wr"}, {31'b0, wr}, 32'd1);
      checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
      checkOutput({tag, "_wait"}, {31'b0, sw}, 32'd0);
   endtask

   task automatic doRdMask(input string tag);
      logic [31:0] rd; logic wr; int lat; logic sw;
      applyStimulus(tag, F_RDMASK, $urandom, $urandom, rd, wr, lat, sw);
      checkOutput({tag, "_rd"}, rd, mMask);
      checkOutput({tag, "_wr"}, {31'b0, wr}, 32'd1);
   endtask

   task automatic doClear();
      logic [31:0] rd; logic wr; int lat; logic sw;
      applyStimulus("clear", F_CLEAR, $urandom, $urandom, rd, wr, lat, sw);
      modelClear();
      checkOutput("clear_wr", {31'b0, wr}, 32'd0);
   endtask

   task automatic illegalTest(input string tag, input logic [6:0] opc, input logic [2:0] f3);
      logic seen = 1'b0;
      @(negedge clk);
      pcpi_insn  = {17'h0, f3, 5'd1, opc};
      pcpi_rs1   = $urandom;
      pcpi_rs2   = $urandom;
      pcpi_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (pcpi_ready || pcpi_wait || pcpi_wr) seen = 1'b1;
      end
      pcpi_valid = 1'b0;
      checkOutput(tag, {31'b0, seen}, 32'd0);
   endtask

   task automatic hardReset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      modelReset();
   endtask

   function automatic logic [31:0] rndData();
      int v;
      if ($urandom_range(0, 3) == 0) v = int'($signed(16'($urandom)));
      else v = int'($urandom_range(0, 40)) - 20;
      return {16'($urandom), 16'(v)};
   endfunction

   initial begin
      logic [31:0] rd;
      resetn     = 1'b0;
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      pcpi_rs1   = '0;
      pcpi_rs2   = '0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", {31'b0, pcpi_ready}, 32'd0);
      checkOutput("reset_wait", {31'b0, pcpi_wait}, 32'd0);
      checkOutput("reset_wr", {31'b0, pcpi_wr}, 32'd0);
      checkOutput("reset_rd", pcpi_rd, 32'd0);
      resetn = 1'b1;
      doRdMask("reset_mask");

      // identity times 1..9, threshold 5
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            doWrite(SEL_A, 4'(r), 4'(c), (r == c) ? 32'd1 : 32'd0);
            doWrite(SEL_B, 4'(r), 4'(c), 32'(r*N + c + 1));
            doWrite(SEL_BIAS, 4'(r), 4'(c), 32'd0);
         end
      doWrite(SEL_THR, 4'd0, 4'd0, 32'd5);
      doRun("tp1_run", rd);
      checkOutput("tp1_const", rd, 32'h000001F0);
      doRdAcc("tp1_acc21", 4'd2, 4'd1, rd);
      checkOutput("tp1_acc21_const", rd, 32'h00000008);

      // identity squared with negative bias, reset threshold then -9
      hardReset();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            doWrite(SEL_A, 4'(r), 4'(c), (r == c) ? 32'd1 : 32'd0);
            doWrite(SEL_B, 4'(r), 4'(c), (r == c) ? 32'd1 : 32'd0);
            doWrite(SEL_BIAS, 4'(r), 4'(c), 32'hFFFF_FFF6);
         end
      doRun("tp2_run", rd);
      checkOutput("tp2_const", rd, 32'h000001FF);
      doWrite(SEL_THR, 4'd0, 4'd0, 32'h0000FFF7);
      doRun("tp2_run9", rd);
      checkOutput("tp2_run9_const", rd, 32'h00000111);
      doRdAcc("tp2_acc11", 4'd1, 4'd1, rd);
      checkOutput("tp2_acc11_const", rd, 32'hFFFFFFF7);

      // most negative operand squared
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            doWrite(SEL_A, 4'(r), 4'(c), (r == 0 && c == 0) ? 32'h8000 : 32'd0);
            doWrite(SEL_B, 4'(r), 4'(c), (r == 0 && c == 0) ? 32'h8000 : 32'd0);
            doWrite(SEL_BIAS, 4'(r), 4'(c), 32'd0);
         end
      doRun("tp3_run", rd);
      doRdAcc("tp3_acc00", 4'd0, 4'd0, rd);
      checkOutput("tp3_acc00_const", rd, 32'h40000000);

      // unclaimed instructions
      illegalTest("illegal_opcode", 7'b0110011, 3'b000);
      illegalTest("illegal_f3_100", OPC, 3'b100);
      illegalTest("illegal_f3_101", OPC, 3'b101);
      illegalTest("illegal_f3_110", OPC, 3'b110);

      // reset asserted in the middle of a run
      @(negedge clk);
      pcpi_insn  = {17'h0, F_RUN, 5'd1, OPC};
      pcpi_valid = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrun_wait_before", {31'b0, pcpi_wait}, 32'd1);
      resetn = 1'b0;
      #1;
      checkOutput("midrun_ready", {31'b0, pcpi_ready}, 32'd0);
      checkOutput("midrun_wait", {31'b0, pcpi_wait}, 32'd0);
      checkOutput("midrun_wr", {31'b0, pcpi_wr}, 32'd0);
      checkOutput("midrun_rd", pcpi_rd, 32'd0);
      pcpi_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      modelReset();
      doRdMask("midrun_mask");
      doRdAcc("midrun_acc00", 4'd0, 4'd0, rd);

      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         for (int s = 0; s < 3; s++)
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  if ($urandom_range(0, 1) == 1) doWrite(2'(s), 4'(r), 4'(c), rndData());
         if ($urandom_range(0, 2) == 0)
            doWrite(SEL_THR, 4'($urandom), 4'($urandom), {16'($urandom), 16'(int'($urandom_range(0, 600)) - 300)});
         if ($urandom_range(0, 3) == 0)
            doWrite(2'($urandom_range(0, 2)), 4'($urandom_range(N, 15)), 4'($urandom_range(0, 15)), rndData());
         if ($urandom_range(0, 3) == 0)
            doWrite(2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(N, 15)), rndData());
         doRun("rnd_run", rd);
         repeat (2) doRdAcc("rnd_acc", 4'($urandom_range(0, N)), 4'($urandom_range(0, N)), rd);
         doRdMask("rnd_mask");
         if ($urandom_range(0, 4) == 0) begin
            doClear();
            doRdMask("rnd_clr_mask");
            doRdAcc("rnd_clr_acc", 4'($urandom_range(0, N-1)), 4'($urandom_range(0, N-1)), rd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
